// File: rtl/bp_cce_lce_in_arbiter.sv
// Round-robin arbiter feeding one registered output slot into the CCE LCE-request port.
// Includes a freeze control for boot/config and a saturating stall counter for debug.
module bp_cce_lce_in_arbiter #(
  parameter int num_req_p         = 4,
  parameter int width_p           = 64,
  parameter int stall_cnt_width_p = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           freeze_i,
  input  logic [num_req_p*width_p-1:0]   req_data_i,
  input  logic [num_req_p-1:0]           req_v_i,
  output logic [num_req_p-1:0]           req_yumi_o,
  output logic [width_p-1:0]             data_o,
  output logic [$clog2(num_req_p)-1:0]   src_o,
  output logic                           v_o,
  input  logic                           ready_i,
  output logic [stall_cnt_width_p-1:0]   stall_cnt_o
);

  localparam int src_width_lp = $clog2(num_req_p);

  logic                         out_v_r;
  logic [width_p-1:0]           out_data_r;
  logic [src_width_lp-1:0]      out_src_r;
  logic [src_width_lp-1:0]      rr_ptr_r;
  logic [stall_cnt_width_p-1:0] stall_cnt_r;

  logic                         space_s;
  logic                         accept_s;
  logic [src_width_lp:0]        cand_s;
  logic [src_width_lp-1:0]      grant_idx_s;

  // Yumi is suppressed during reset so no requester drops a message that is then lost.
  assign space_s  = ~out_v_r | ready_i;
  assign accept_s = reset_n_i & ~freeze_i & (|req_v_i) & space_s;

  // Round-robin search; farthest offset first so the nearest valid requester after rr_ptr_r wins.
  always_comb begin
    grant_idx_s = '0;
    cand_s      = '0;
    for (int off = num_req_p; off >= 1; off--) begin
      cand_s = {1'b0, rr_ptr_r} + (src_width_lp+1)'(off);
      if (cand_s >= (src_width_lp+1)'(num_req_p)) begin
        cand_s = cand_s - (src_width_lp+1)'(num_req_p);
      end else begin
        cand_s = cand_s;
      end
      if (req_v_i[cand_s[src_width_lp-1:0]]) begin
        grant_idx_s = cand_s[src_width_lp-1:0];
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
  end

  // One-hot consume acknowledge for the selected requester.
  always_comb begin
    req_yumi_o = '0;
    if (accept_s) begin
      req_yumi_o[grant_idx_s] = 1'b1;
    end else begin
      req_yumi_o = '0;
    end
  end

  // Output slot and pointer: accept overwrites even while draining, so no bubble appears.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_v_r    <= 1'b0;
      out_data_r <= '0;
      out_src_r  <= '0;
      rr_ptr_r   <= src_width_lp'(num_req_p - 1);
    end else if (accept_s) begin
      out_v_r    <= 1'b1;
      out_data_r <= req_data_i[grant_idx_s*width_p +: width_p];
      out_src_r  <= grant_idx_s;
      rr_ptr_r   <= grant_idx_s;
    end else if (out_v_r & ready_i) begin
      out_v_r    <= 1'b0;
    end
  end

  // Saturating count of cycles where someone is waiting but nothing was granted.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt_r <= '0;
    end else if ((|req_v_i) & ~accept_s & ~(&stall_cnt_r)) begin
      stall_cnt_r <= stall_cnt_r + stall_cnt_width_p'(1);
    end
  end

  assign v_o         = out_v_r;
  assign data_o      = out_data_r;
  assign src_o       = out_src_r;
  assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_bp_cce_lce_in_arbiter.sv
// Bench for bp_cce_lce_in_arbiter: hand-derived per-cycle vector table plus a message scoreboard.
module tb_bp_cce_lce_in_arbiter;

  logic         clk;
  logic         clk_en;
  logic         reset_n;
  logic         freeze;
  logic [255:0] req_data;
  logic [3:0]   req_v;
  logic [3:0]   req_yumi;
  logic [63:0]  data_o;
  logic [1:0]   src_o;
  logic         v_o;
  logic         ready;
  logic [3:0]   stall_cnt;

  bp_cce_lce_in_arbiter #(
    .num_req_p(4), .width_p(64), .stall_cnt_width_p(4)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze), .req_data_i(req_data),
    .req_v_i(req_v), .req_yumi_o(req_yumi), .data_o(data_o), .src_o(src_o),
    .v_o(v_o), .ready_i(ready), .stall_cnt_o(stall_cnt)
  );

  typedef struct {
    logic       rst;
    logic       ld;
    logic       frz;
    logic [3:0] rv;
    logic       rdy;
    logic [3:0] yumi;
    logic       v;
    logic [1:0] src;
    logic [3:0] stall;
  } vec_t;

  typedef struct {
    logic [1:0]  src;
    logic [63:0] data;
  } msg_t;

  vec_t        tbl[$];
  msg_t        sb[$];
  logic [59:0] msg_cnt [4];
  int          checks;
  int          errors;

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [63:0] data_of(int k);
    return {4'(k), msg_cnt[k]};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void add(logic rst, logic ld, logic frz, logic [3:0] rv, logic rdy,
                              logic [3:0] yumi, logic v, logic [1:0] src, logic [3:0] stall);
    tbl.push_back('{rst, ld, frz, rv, rdy, yumi, v, src, stall});
  endfunction

  task automatic drive_data();
    for (int k = 0; k < 4; k++) req_data[k*64 +: 64] = data_of(k);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    freeze  = 1'b0;
    req_v   = 4'hF;
    ready   = 1'b1;
    #1;
    chk("rst_v", 64'(v_o), 64'd0);
    chk("rst_data", data_o, 64'd0);
    chk("rst_src", 64'(src_o), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    chk("rst_yumi", 64'(req_yumi), 64'd0);
    sb.delete();
    @(negedge clk);
    req_v   = 4'h0;
    reset_n = 1'b1;
  endtask

  task automatic run_row(vec_t r);
    msg_t m;
    @(negedge clk);
    if (r.ld) msg_cnt[0] = 60'h1234;
    freeze = r.frz;
    req_v  = r.rv;
    ready  = r.rdy;
    drive_data();
    #1;
    chk("yumi", 64'(req_yumi), 64'(r.yumi));
    chk("v_o", 64'(v_o), 64'(r.v));
    chk("src_o", 64'(src_o), 64'(r.src));
    chk("stall", 64'(stall_cnt), 64'(r.stall));
    if (v_o && r.rdy) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_output", 64'd1, 64'd0);
      end else begin
        m = sb.pop_front();
        chk("sb_data", data_o, m.data);
        chk("sb_src", 64'(src_o), 64'(m.src));
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (r.yumi[k]) begin
        sb.push_back('{2'(k), data_of(k)});
        msg_cnt[k] = msg_cnt[k] + 60'd1;
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    clk_en  = 1'b1;
    reset_n = 1'b0;
    freeze  = 1'b0;
    req_v   = 4'h0;
    ready   = 1'b0;
    for (int k = 0; k < 4; k++) msg_cnt[k] = 60'h100 * 60'(k + 1);
    drive_data();

    // Round robin out of reset: 0,1,2,3,0,1 back to back
    add(1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 4'd0);
    add(1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 4'd0);
    add(1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 4'd0);
    add(1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 4'd0);
    add(1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 4'd0);
    add(1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 4'd0);
    // Backpressure: hold req0 for 5 cycles, then req2
    add(1'b1, 1'b0, 1'b0, 4'b0101, 1'b0, 4'b0001, 1'b0, 2'd0, 4'd0);
    for (int i = 0; i < 5; i++)
      add(1'b0, 1'b0, 1'b0, 4'b0101, 1'b0, 4'b0000, 1'b1, 2'd0, 4'(i));
    add(1'b0, 1'b0, 1'b0, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd0, 4'd5);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 4'd5);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 4'd5);
    // Pointer wrap
    add(1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 4'b1000, 1'b0, 2'd2, 4'd5);
    add(1'b0, 1'b0, 1'b0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd3, 4'd5);
    add(1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd0, 4'd5);
    add(1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 4'd5);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 4'd5);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 4'd5);
    // Freeze: held 64'h1234 drains, no grants until release
    add(1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0, 2'd3, 4'd5);
    add(1'b0, 1'b0, 1'b1, 4'b0011, 1'b0, 4'b0000, 1'b1, 2'd0, 4'd5);
    add(1'b0, 1'b0, 1'b1, 4'b0011, 1'b1, 4'b0000, 1'b1, 2'd0, 4'd6);
    add(1'b0, 1'b0, 1'b1, 4'b0011, 1'b1, 4'b0000, 1'b0, 2'd0, 4'd7);
    add(1'b0, 1'b0, 1'b0, 4'b0011, 1'b1, 4'b0010, 1'b0, 2'd0, 4'd8);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 4'd8);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 4'd8);
    // Saturation of the 4-bit stall counter
    add(1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0, 2'd1, 4'd8);
    for (int i = 0; i < 20; i++)
      add(1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0, (8 + i > 15) ? 4'd15 : 4'(8 + i));
    add(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 4'd15);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 4'd15);
    // Load the slot ahead of the async reset sequence
    add(1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0, 2'd0, 4'd15);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 4'd15);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      run_row(tbl[i]);
    end

    // Async reset with the clock stopped low
    clk_en = 1'b0;
    #3;
    req_v = 4'b0100;
    ready = 1'b1;
    #1;
    chk("pre_areset_yumi", 64'(req_yumi), 64'b0100);
    chk("pre_areset_v", 64'(v_o), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("areset_v", 64'(v_o), 64'd0);
    chk("areset_stall", 64'(stall_cnt), 64'd0);
    chk("areset_yumi", 64'(req_yumi), 64'd0);
    chk("areset_data", data_o, 64'd0);
    sb.delete();
    req_v = 4'b0000;
    #10;
    reset_n = 1'b1;
    #3;
    clk_en = 1'b1;
    run_row('{1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 4'd0});
    run_row('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 4'd0});
    chk("sb_empty_at_end", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
